// File: rtl/hamming_tx_serializer.sv
// Word FIFO + MSB-first serializer feeding a (15,11) Hamming encoder, one bit per DIV clocks.
// Optional sticky UNDERRUN output is enabled by defining HAMMING_TX_UNDERRUN_FLAG_EN.
module hamming_tx_serializer #(
  parameter int DATA_W = 11,
  parameter int DIV    = 15,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     REST,
  input  logic [DATA_W-1:0]        DATA_IN,
  input  logic                     DATA_VALID,
  output logic                     DATA_READY,
  output logic                     SERIAL_OUT,
  output logic                     DEVICE_EN,
  output logic                     WORD_START,
`ifdef HAMMING_TX_UNDERRUN_FLAG_EN
  output logic                     UNDERRUN,
`endif
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_word_start;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;

  logic w_tick;
  logic w_last_bit;
  logic w_boundary;
  logic w_fifo_nempty;
  logic w_push;
  logic w_load;
  logic w_advance;

  assign w_tick        = (r_cnt == CW'(DIV - 1));
  assign w_last_bit    = (r_idx == IW'(DATA_W - 1));
  assign w_fifo_nempty = (r_level != '0);
  assign w_boundary    = w_tick && ((r_state == S_IDLE) || w_last_bit);

  // Ready comes from the registered level only, so a pop while full frees the slot next cycle.
  assign DATA_READY = REST && (r_level < LW'(DEPTH));
  assign w_push     = DATA_VALID && DATA_READY;

  assign SERIAL_OUT = (r_state == S_SHIFT) && r_shift[DATA_W-1];
  assign DEVICE_EN  = (r_state == S_SHIFT);
  assign WORD_START = r_word_start;
  assign FIFO_LEVEL = r_level;

  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    if (w_boundary) begin
      if (w_fifo_nempty) begin
        w_load       = 1'b1;
        w_next_state = S_SHIFT;
      end else begin
        w_next_state = S_IDLE;
      end
    end else if (w_tick && (r_state == S_SHIFT)) begin
      w_advance = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_word_start <= 1'b0;
    end else begin
      r_cnt        <= w_tick ? '0 : r_cnt + CW'(1);
      r_word_start <= w_load;
      if (w_load) begin
        r_shift <= r_mem[r_rd_ptr];
        r_idx   <= '0;
      end else if (w_advance) begin
        r_shift <= r_shift << 1;
        r_idx   <= r_idx + IW'(1);
      end
    end
  end

  // Storage needs no reset: pointers and level define which entries are valid.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_load) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      end
      case ({w_push, w_load})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef HAMMING_TX_UNDERRUN_FLAG_EN
  logic r_underrun;

  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      r_underrun <= 1'b0;
    end else if (w_tick && (r_state == S_SHIFT) && w_last_bit && !w_fifo_nempty) begin
      r_underrun <= 1'b1;
    end
  end

  assign UNDERRUN = r_underrun;
`endif

endmodule
